// File: rtl/branch_prog_ctr_pkg.sv
// Shared types for the branch program counter: branch-op encodings and FSM states.
package prog_ctr_pkg;

  localparam int unsigned BROP_W = 3;

  typedef enum logic [BROP_W-1:0] {
    BROP_NONE    = 3'd0,
    BROP_JMP_ABS = 3'd1,
    BROP_JMP_REL = 3'd2,
    BROP_BR_ABS  = 3'd3,
    BROP_BR_REL  = 3'd4,
    BROP_CALL    = 3'd5,
    BROP_RET     = 3'd6,
    BROP_HALT    = 3'd7
  } brop_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/branch_prog_ctr_if.sv
// Control/status bundle between the sequencer front end and the program counter.
interface branch_prog_ctr_if
  import prog_ctr_pkg::*;
#(
  parameter int unsigned L  = 10,
  parameter int unsigned OW = 8,
  parameter int unsigned D  = 4
) ();

  localparam int unsigned DW = $clog2(D + 1);

  logic          i_start;
  logic          i_stall;
  brop_t         i_brop;
  logic          i_cond;
  logic [L-1:0]  i_target;
  logic [OW-1:0] i_offset;
  logic [L-1:0]  o_prog_ctr;
  logic          o_halted;
  logic [DW-1:0] o_stk_depth;
  logic          o_stk_err;

  modport master (
    output i_start, i_stall, i_brop, i_cond, i_target, i_offset,
    input  o_prog_ctr, o_halted, o_stk_depth, o_stk_err
  );

  modport slave (
    input  i_start, i_stall, i_brop, i_cond, i_target, i_offset,
    output o_prog_ctr, o_halted, o_stk_depth, o_stk_err
  );

endinterface

// File: rtl/branch_prog_ctr_ret_stack.sv
// LIFO of return addresses; callers only push when not full and pop when not empty.
module ret_stack #(
  parameter int unsigned L = 10,
  parameter int unsigned D = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [L-1:0]             i_data,
  output logic [L-1:0]             o_top,
  output logic [$clog2(D+1)-1:0]   o_depth,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned DW = $clog2(D + 1);
  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned NE = 1 << IW;

  logic [L-1:0]  r_mem [NE];
  logic [DW-1:0] r_depth;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_wr_idx  = IW'(r_depth);
  assign w_rd_idx  = IW'(r_depth - DW'(1));
  assign o_full    = (r_depth == DW'(D));
  assign o_empty   = (r_depth == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_top     = r_mem[w_rd_idx];
  assign o_depth   = r_depth;

  // Entry storage carries no reset; the depth count alone defines validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DW'(1);
    end
  end

endmodule

// File: rtl/branch_prog_ctr.sv
// Program counter with absolute/relative jumps, conditional branches, call/return stack and halt.
module branch_prog_ctr
  import prog_ctr_pkg::*;
#(
  parameter int unsigned L  = 10,
  parameter int unsigned OW = 8,
  parameter int unsigned D  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  branch_prog_ctr_if.slave   bus
);

  localparam int unsigned DW = $clog2(D + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [L-1:0]  r_pc;
  logic [L-1:0]  w_pc_nxt;
  logic [L-1:0]  w_pc_inc;
  logic [L-1:0]  w_pc_rel;
  logic [L-1:0]  w_stk_top;
  logic          r_stk_err;
  logic          w_err_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [DW-1:0] w_depth;
  logic          w_frozen;

  assign w_pc_inc = r_pc + L'(1);
  assign w_pc_rel = r_pc + L'($signed(bus.i_offset));
  assign w_frozen = bus.i_start || bus.i_stall;

  ret_stack #(.L(L), .D(D)) u_ret_stack (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_stk_top),
    .o_depth (w_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state / next-PC decode; hold requests and S_HALT suppress every update.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_err_nxt   = r_stk_err;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if (!w_frozen && (r_state == S_RUN)) begin
      w_pc_nxt = w_pc_inc;
      case (bus.i_brop)
        BROP_JMP_ABS: w_pc_nxt = bus.i_target;
        BROP_JMP_REL: w_pc_nxt = w_pc_rel;
        BROP_BR_ABS:  if (bus.i_cond) w_pc_nxt = bus.i_target;
        BROP_BR_REL:  if (bus.i_cond) w_pc_nxt = w_pc_rel;
        BROP_CALL: begin
          if (w_full) begin
            w_err_nxt = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = bus.i_target;
          end
        end
        BROP_RET: begin
          if (w_empty) begin
            w_err_nxt = 1'b1;
          end else begin
            w_pop    = 1'b1;
            w_pc_nxt = w_stk_top;
          end
        end
        BROP_HALT: begin
          w_pc_nxt    = r_pc;
          w_state_nxt = S_HALT;
        end
        default: w_pc_nxt = w_pc_inc;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc      <= '0;
      r_stk_err <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_stk_err <= w_err_nxt;
    end
  end

  assign bus.o_prog_ctr  = r_pc;
  assign bus.o_halted    = (r_state == S_HALT);
  assign bus.o_stk_depth = w_depth;
  assign bus.o_stk_err   = r_stk_err;

endmodule

// File: tb/tb_branch_prog_ctr.sv
// Directed and randomized checks of branch_prog_ctr against a queue-based behavioural model.
module tb_branch_prog_ctr;
  import prog_ctr_pkg::*;

  localparam int unsigned L  = 10;
  localparam int unsigned OW = 8;
  localparam int unsigned D  = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  branch_prog_ctr_if #(.L(L), .OW(OW), .D(D)) bus ();

  branch_prog_ctr #(.L(L), .OW(OW), .D(D)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: PC as an integer, return stack as a queue.
  int m_pc;
  int m_stk[$];
  bit m_halt;
  bit m_err;

  function automatic logic [14:0] pack(input int pc, input bit h, input int d, input bit e);
    return {10'(pc), h, 3'(d), e};
  endfunction

  function automatic logic [14:0] obs();
    return {bus.o_prog_ctr, bus.o_halted, bus.o_stk_depth, bus.o_stk_err};
  endfunction

  task automatic model_step();
    int off;
    off = int'($signed(bus.i_offset));
    if (rst) begin
      m_pc = 0; m_stk.delete(); m_halt = 0; m_err = 0;
    end else if (bus.i_start || bus.i_stall || m_halt) begin
      // frozen
    end else begin
      case (bus.i_brop)
        BROP_JMP_ABS: m_pc = int'(bus.i_target);
        BROP_JMP_REL: m_pc = (m_pc + off) & 1023;
        BROP_BR_ABS:  m_pc = bus.i_cond ? int'(bus.i_target) : (m_pc + 1) & 1023;
        BROP_BR_REL:  m_pc = bus.i_cond ? (m_pc + off) & 1023 : (m_pc + 1) & 1023;
        BROP_CALL: begin
          if (m_stk.size() < D) begin
            m_stk.push_back((m_pc + 1) & 1023);
            m_pc = int'(bus.i_target);
          end else begin
            m_err = 1; m_pc = (m_pc + 1) & 1023;
          end
        end
        BROP_RET: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_err = 1; m_pc = (m_pc + 1) & 1023; end
        end
        BROP_HALT: m_halt = 1;
        default: m_pc = (m_pc + 1) & 1023;
      endcase
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit sl, input brop_t op,
                       input bit c, input int tgt, input int off);
    rst = r;
    bus.i_start  = st;
    bus.i_stall  = sl;
    bus.i_brop   = op;
    bus.i_cond   = c;
    bus.i_target = 10'(tgt);
    bus.i_offset = 8'(off);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic op_tick(input brop_t op, input bit c, input int tgt, input int off);
    drive(0, 0, 0, op, c, tgt, off);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 1, BROP_JMP_ABS, 1, 77, 0);
    tick();
    n_checks++;
    if (obs() !== pack(0, 0, 0, 0)) $display("FAIL reset: got %h want %h", obs(), pack(0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_none_wrap();
    drive(1, 0, 0, BROP_NONE, 0, 0, 0); tick();
    for (int k = 1; k <= 5; k++) begin
      op_tick(BROP_NONE, 0, 0, 0);
      n_checks++;
      if (bus.o_prog_ctr !== 10'(k)) $display("FAIL none_step%0d: got %0d want %0d", k, bus.o_prog_ctr, k);
      else n_pass++;
    end
    op_tick(BROP_JMP_ABS, 0, 1023, 0);
    op_tick(BROP_NONE, 0, 0, 0);
    n_checks++;
    if (bus.o_prog_ctr !== 10'd0) $display("FAIL none_wrap: got %0d want 0", bus.o_prog_ctr);
    else n_pass++;
  endtask

  task automatic test_rel_branch();
    logic [9:0] want [4] = '{10'd6, 10'd7, 10'd200, 10'd195};
    op_tick(BROP_JMP_ABS, 0, 10, 0);
    op_tick(BROP_JMP_REL, 0, 0, 8'hFC);
    n_checks++;
    if (bus.o_prog_ctr !== want[0]) $display("FAIL jmp_rel_neg: got %0d want %0d", bus.o_prog_ctr, want[0]);
    else n_pass++;
    op_tick(BROP_BR_ABS, 0, 200, 0);
    n_checks++;
    if (bus.o_prog_ctr !== want[1]) $display("FAIL br_abs_nt: got %0d want %0d", bus.o_prog_ctr, want[1]);
    else n_pass++;
    op_tick(BROP_BR_ABS, 1, 200, 0);
    n_checks++;
    if (bus.o_prog_ctr !== want[2]) $display("FAIL br_abs_t: got %0d want %0d", bus.o_prog_ctr, want[2]);
    else n_pass++;
    op_tick(BROP_BR_REL, 1, 0, 8'hFB);
    n_checks++;
    if (bus.o_prog_ctr !== want[3]) $display("FAIL br_rel_t: got %0d want %0d", bus.o_prog_ctr, want[3]);
    else n_pass++;
  endtask

  task automatic test_call_ret();
    op_tick(BROP_JMP_ABS, 0, 20, 0);
    op_tick(BROP_CALL, 0, 100, 0);
    n_checks++;
    if (obs() !== pack(100, 0, 1, 0)) $display("FAIL call: got %h want %h", obs(), pack(100, 0, 1, 0));
    else n_pass++;
    op_tick(BROP_RET, 0, 0, 0);
    n_checks++;
    if (obs() !== pack(21, 0, 0, 0)) $display("FAIL ret: got %h want %h", obs(), pack(21, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_overflow();
    int rets [4] = '{301, 201, 101, 1};
    drive(1, 0, 0, BROP_NONE, 0, 0, 0); tick();
    for (int k = 1; k <= 4; k++) op_tick(BROP_CALL, 0, k * 100, 0);
    n_checks++;
    if (obs() !== pack(400, 0, 4, 0)) $display("FAIL call_full: got %h want %h", obs(), pack(400, 0, 4, 0));
    else n_pass++;
    op_tick(BROP_CALL, 0, 500, 0);
    n_checks++;
    if (obs() !== pack(401, 0, 4, 1)) $display("FAIL call_ovf: got %h want %h", obs(), pack(401, 0, 4, 1));
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      op_tick(BROP_RET, 0, 0, 0);
      n_checks++;
      if (obs() !== pack(rets[k], 0, 3 - k, 1)) $display("FAIL ret_pop%0d: got %h want %h", k, obs(), pack(rets[k], 0, 3 - k, 1));
      else n_pass++;
    end
    drive(1, 0, 0, BROP_NONE, 0, 0, 0); tick();
    op_tick(BROP_RET, 0, 0, 0);
    n_checks++;
    if (obs() !== pack(1, 0, 0, 1)) $display("FAIL ret_udf: got %h want %h", obs(), pack(1, 0, 0, 1));
    else n_pass++;
  endtask

  task automatic test_stall_halt();
    drive(1, 0, 0, BROP_NONE, 0, 0, 0); tick();
    op_tick(BROP_CALL, 0, 50, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, BROP_JMP_ABS, 1, 300, 0); tick();
      n_checks++;
      if (obs() !== pack(50, 0, 1, 0)) $display("FAIL stall%0d: got %h want %h", k, obs(), pack(50, 0, 1, 0));
      else n_pass++;
    end
    drive(0, 1, 0, BROP_RET, 0, 0, 0); tick();
    n_checks++;
    if (obs() !== pack(50, 0, 1, 0)) $display("FAIL start_hold: got %h want %h", obs(), pack(50, 0, 1, 0));
    else n_pass++;
    op_tick(BROP_HALT, 0, 0, 0);
    n_checks++;
    if (obs() !== pack(50, 1, 1, 0)) $display("FAIL halt: got %h want %h", obs(), pack(50, 1, 1, 0));
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      op_tick(brop_t'(3'(k)), 1, 900, 8'h7F);
      n_checks++;
      if (obs() !== pack(50, 1, 1, 0)) $display("FAIL halt_hold%0d: got %h want %h", k, obs(), pack(50, 1, 1, 0));
      else n_pass++;
    end
    drive(1, 0, 1, BROP_CALL, 0, 5, 0); tick();
    n_checks++;
    if (obs() !== pack(0, 0, 0, 0)) $display("FAIL halt_reset: got %h want %h", obs(), pack(0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_random();
    int r;
    drive(1, 0, 0, BROP_NONE, 0, 0, 0); tick();
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      drive(r < 4, (r >= 4) && (r < 8), (r >= 8) && (r < 16),
            brop_t'(3'($urandom)), 1'($urandom), int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 255)));
      tick();
      n_checks++;
      if (obs() !== pack(m_pc, m_halt, m_stk.size(), m_err))
        $display("FAIL rand%0d: got pc=%0d h=%0d d=%0d e=%0d want pc=%0d h=%0d d=%0d e=%0d",
                 n, bus.o_prog_ctr, bus.o_halted, bus.o_stk_depth, bus.o_stk_err,
                 m_pc, m_halt, m_stk.size(), m_err);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_pc = 0; m_halt = 0; m_err = 0;
    drive(1, 0, 0, BROP_NONE, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_none_wrap();
    test_rel_branch();
    test_call_ret();
    test_overflow();
    test_stall_halt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_prog_ctr.md
BRANCH_PROG_CTR -- requirements
Module: branch_prog_ctr

Interface
REQ-001 Parameter L, default 10: program counter width in bits; SHALL equal the instruction ROM address width.
REQ-002 Parameter OW, default 8: signed relative-offset width; SHALL satisfy 2 <= OW <= L.
REQ-003 Parameter D, default 4: return-stack depth in entries; SHALL be >= 1.
REQ-004 Clk, input, 1: the single clock; all state changes occur on its rising edge only.
REQ-005 Reset, input, 1: synchronous, active-high reset; it takes effect only on a rising edge of Clk.
REQ-006 Start, input, 1: hold request; while high, PC, FSM state and stack are frozen.
REQ-007 Stall, input, 1: pipeline stall; while high, PC, FSM state and stack are frozen.
REQ-008 BrOp, input, 3: operation select from brop_t: NONE, JMP_ABS, JMP_REL, BR_ABS, BR_REL, CALL, RET, HALT.
REQ-009 Cond, input, 1: branch condition, qualifying BR_ABS and BR_REL only.
REQ-010 Target, input, L: absolute destination for JMP_ABS, BR_ABS and CALL.
REQ-011 Offset, input, OW: two's-complement displacement, relative to current PC, for JMP_REL and BR_REL.
REQ-012 ProgCtr, output, L: program counter register.
REQ-013 Halted, output, 1: high while the FSM is in S_HALT.
REQ-014 StkDepth, output, $clog2(D+1): number of valid return-stack entries.
REQ-015 StkErr, output, 1: sticky flag for stack overflow or underflow.

Function
REQ-016 The FSM SHALL have two states: S_RUN and S_HALT.
REQ-017 Per-edge priority SHALL be: Reset > Start > Stall > S_HALT hold > BrOp decode.
REQ-018 In S_RUN, NONE SHALL set ProgCtr <= ProgCtr+1, modulo 2^L.
REQ-019 JMP_ABS SHALL set ProgCtr <= Target.
REQ-020 JMP_REL SHALL set ProgCtr <= ProgCtr + sign-extended Offset, modulo 2^L.
REQ-021 BR_ABS and BR_REL SHALL behave as JMP_ABS and JMP_REL respectively when Cond=1, and as NONE when Cond=0.
REQ-022 CALL with StkDepth<D SHALL push ProgCtr+1 (mod 2^L), increment StkDepth, and set ProgCtr <= Target, all in the same edge.
REQ-023 CALL with StkDepth==D (full) SHALL leave the stack unchanged, set StkErr, and behave as NONE.
REQ-024 RET with StkDepth>0 SHALL set ProgCtr <= top entry and decrement StkDepth.
REQ-025 RET with StkDepth==0 (empty) SHALL set StkErr and behave as NONE.
REQ-026 HALT SHALL hold ProgCtr and move the FSM to S_HALT on the same edge.
REQ-027 In S_HALT, ProgCtr, stack and StkErr SHALL hold regardless of BrOp; only Reset leaves S_HALT.
REQ-028 Latency: every update SHALL be visible on ProgCtr one Clk edge after the qualifying inputs are sampled; there SHALL be no combinational path from any input to any output.
REQ-029 StkErr, once set, SHALL remain set until Reset.
REQ-030 Undefined BrOp encodings SHALL behave as NONE.

Reset
REQ-031 Reset SHALL set ProgCtr=0, FSM=S_RUN, StkDepth=0, StkErr=0 and Halted=0, overriding Start, Stall and BrOp.
REQ-032 Reset asserted mid-operation (during a CALL, in S_HALT, or while Stall is high) SHALL discard all stack contents; there is no partial state.
REQ-033 Stack entry storage need not be reset; entries are invalid while StkDepth==0.

Structure
REQ-034 Package prog_ctr_pkg SHALL hold brop_t (3-bit enum), the state_t enum {S_RUN, S_HALT} and the BROP_* encoding constants.
REQ-035 The return stack SHALL be a sub-module ret_stack #(L,D) with push, pop, top, depth, full and empty signals; branch_prog_ctr owns the FSM and next-PC mux.

Verification (L=10, OW=8, D=4)
REQ-036 Reset, then 5 edges of NONE -> ProgCtr 0,1,2,3,4,5; ProgCtr=1023 followed by NONE -> ProgCtr=0.
REQ-037 ProgCtr=10, JMP_REL Offset=8'hFC -> ProgCtr=6; BR_ABS Target=200 with Cond=0 -> ProgCtr=7, with Cond=1 -> ProgCtr=200.
REQ-038 ProgCtr=20, CALL Target=100 -> ProgCtr=100, StkDepth=1; RET -> ProgCtr=21, StkDepth=0.
REQ-039 Five nested CALLs from depth 0 -> StkDepth=4, fifth CALL yields PC+1 and StkErr=1; RET at depth 0 -> PC+1 and StkErr=1.
REQ-040 Stall=1 for 3 edges with BrOp=JMP_ABS -> ProgCtr unchanged; HALT -> Halted=1 and ProgCtr frozen under any BrOp; Reset -> ProgCtr=0, Halted=0, StkDepth=0, StkErr=0.
